// File: rtl/audio_pll_seq_pkg.sv
// rtl/audio_pll_seq_pkg.sv - shared types, widths and helpers for the audio PLL lock sequencer
package audio_pll_seq_pkg;

   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } seq_state_t;

   // Width of the shared counter: enough bits to hold the largest terminal count.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer with asynchronous active-low reset
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give a metastable first stage a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/audio_pll_lock_sequencer.sv
// rtl/audio_pll_lock_sequencer.sv - audio PLL reset/lock/retry sequencer; AUDIO_PLL_SEQ_LOSS_CNT_EN builds the lock-loss counter
module audio_pll_lock_sequencer
   import audio_pll_seq_pkg::*;
#(
   parameter int POR_CYCLES     = 64,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES    = 3
) (
   input  logic               refclk,
   input  logic               rst_n,
   input  logic               relock_req,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOSS_W-1:0]  loss_cnt
);

   localparam int CNT_W = cnt_width(POR_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

   // Terminal counts: each state counts 0..N-1 and never wraps.
   localparam logic [CNT_W-1:0]   POR_LAST     = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   seq_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry_q;
   logic [RETRY_W-1:0] retry_inc;
   logic               pll_rst_q;
   logic               ready_q;
   logic               fault_q;
   logic               lock_s;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   // Saturating next value of the failed-attempt count.
   always_comb begin
      retry_inc = retry_q;
      if (retry_q != {RETRY_W{1'b1}}) retry_inc = retry_q + RETRY_ONE;
   end

`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
   localparam logic [LOSS_W-1:0] LOSS_ONE = LOSS_W'(1);
   logic [LOSS_W-1:0] loss_q;
`endif

   // Sequencer FSM: relock_req wins over every in-state event; outputs are registered.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HOLD;
         cnt       <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
         loss_q    <= '0;
`endif
      end else if (relock_req) begin
         state     <= HOLD;
         cnt       <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               pll_rst_q <= 1'b1;
               if (cnt == POR_LAST) begin
                  state     <= WAIT_LOCK;
                  cnt       <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt       <= '0;
                  retry_q   <= retry_inc;
                  pll_rst_q <= 1'b1;
                  if (retry_inc == RETRY_MAX) begin
                     state   <= FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state <= HOLD;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STABLE: begin
               // A dropout restarts the lock wait; only a clean window reaches RUN.
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state   <= RUN;
                  cnt     <= '0;
                  ready_q <= 1'b1;
                  retry_q <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state     <= HOLD;
                  cnt       <= '0;
                  ready_q   <= 1'b0;
                  pll_rst_q <= 1'b1;
`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
                  if (loss_q != {LOSS_W{1'b1}}) loss_q <= loss_q + LOSS_ONE;
`endif
               end
            end
            FAULT: begin
               pll_rst_q <= 1'b1;
               fault_q   <= 1'b1;
               ready_q   <= 1'b0;
            end
            default: begin
               state     <= HOLD;
               cnt       <= '0;
               pll_rst_q <= 1'b1;
               ready_q   <= 1'b0;
               fault_q   <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst   = pll_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;

`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
   assign loss_cnt = loss_q;
`else
   assign loss_cnt = '0;
`endif

endmodule
